uart_frame_rx: RTL
==================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter SOF, default 8'hA5, start-of-frame byte.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..DEPTH/2).
REQ-003 SHALL have parameter DEPTH, default 32, payload buffer entries (power of 2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 125_000, max clocks between bytes inside a frame.
REQ-005 SHALL have ports:
  clock  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  rx_data  in  8  byte from UART receiver.
  rx_valid  in  1  one-cycle strobe, rx_data valid.
  local_ready  out  1  to UART receiver, buffer can take more bytes.
  payload_data  out  8  committed payload byte.
  payload_valid  out  1  payload_data valid.
  payload_ready  in  1  consumer accepts byte.
  payload_last  out  1  byte is last of its frame.
  frame_ok  out  1  one-cycle pulse, frame committed.
  frame_err  out  1  one-cycle pulse, frame dropped.
  err_code  out  2  cause, valid with frame_err: 1 length, 2 checksum, 3 timeout/overflow.

Function
REQ-006 Frame format SHALL be: SOF, LEN (1..MAX_LEN), LEN payload bytes, CHK, with CHK = XOR of LEN and all payload bytes.
REQ-007 FSM states SHALL be IDLE, LEN, PAYLOAD, CHECK; IDLE->LEN on rx_valid with rx_data==SOF; all other IDLE bytes are ignored without error.
REQ-008 In LEN, rx_valid with LEN 0 or >MAX_LEN SHALL pulse frame_err, err_code=1, go to IDLE; otherwise latch LEN, seed checksum with LEN, go to PAYLOAD.
REQ-009 In PAYLOAD each byte SHALL be written speculatively to the buffer at the speculative write pointer with a last bit (set on the LEN-th byte) and XORed into the checksum; after the LEN-th byte go to CHECK.
REQ-010 In CHECK, on rx_valid: match SHALL move commit pointer to speculative pointer and pulse frame_ok; mismatch SHALL rewind speculative pointer to commit pointer and pulse frame_err, err_code=2; both go to IDLE.
REQ-011 Pulses SHALL occur in the cycle after the triggering byte is sampled; committed bytes SHALL be visible on payload_valid in that same cycle.
REQ-012 Buffer SHALL be DEPTH x 9 bits; read side SHALL expose only entries between read pointer and commit pointer; a byte transfers when payload_valid && payload_ready.
REQ-013 payload_valid SHALL be high iff commit pointer != read pointer; payload_data/payload_last SHALL be stable while valid && !ready.
REQ-014 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; occupancy = speculative write pointer - read pointer.
REQ-015 local_ready SHALL be registered, high iff DEPTH - occupancy >= 2.
REQ-016 A payload byte arriving with occupancy == DEPTH SHALL be discarded, rewind the speculative pointer, pulse frame_err, err_code=3, go to IDLE.
REQ-017 Outside IDLE, an inter-byte counter SHALL reset on each rx_valid; reaching TIMEOUT_CYCLES SHALL rewind, pulse frame_err, err_code=3, go to IDLE.
REQ-018 Same-cycle read and commit/rewind/write SHALL all take effect; a rewind never discards committed data.
REQ-019 rx_valid in the same cycle as a timeout SHALL be treated as the byte arriving (timeout loses).

Reset
REQ-020 On reset low: state IDLE, all pointers 0, checksum 0, counter 0, payload_valid 0, payload_last 0, payload_data 0, frame_ok 0, frame_err 0, err_code 0, local_ready 1; an in-flight frame is lost.
REQ-021 Buffer contents SHALL need no reset.

Verification
REQ-022 A5 03 11 22 33 03, payload_ready=1 -> frame_ok one pulse; 11,22,33 out, payload_last only on 33.
REQ-023 A5 02 10 20 00 (expected CHK 32) -> frame_err, err_code=2; payload_valid stays 0; next good frame delivered intact.
REQ-024 A5 00 and A5 11 -> frame_err, err_code=1 each; no buffer writes.
REQ-025 A5 04 01 02 then TIMEOUT_CYCLES idle -> frame_err, err_code=3; occupancy back to prior value.
REQ-026 payload_ready=0, frames of 16 bytes sent until local_ready=0 -> two frames committed, third rejected with err_code=3 on its overflowing byte; draining 16 bytes raises local_ready; pointer wrap correct over 5 frames.
REQ-027 Reset low mid-PAYLOAD -> all outputs at reset values next cycle; following frame decoded correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Byte-stream frame receiver: SOF, LEN, payload, XOR checksum. Payload bytes are
// buffered speculatively and only exposed to the consumer once the checksum matches.
module uart_frame_rx #(
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         DEPTH          = 32,
    parameter int         TIMEOUT_CYCLES = 125_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       local_ready,
    output logic [7:0] payload_data,
    output logic       payload_valid,
    input  logic       payload_ready,
    output logic       payload_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHECK} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      len_reg, len_next;
    logic [7:0]      idx_reg, idx_next;
    logic [7:0]      chk_reg, chk_next;
    logic [TW-1:0]   tmo_reg, tmo_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic            local_ready_reg, local_ready_next;
    logic            frame_ok_reg, frame_ok_next;
    logic            frame_err_reg, frame_err_next;
    logic [1:0]      err_code_reg, err_code_next;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [8:0]      mem_wdata;
    logic [8:0]      rdata_reg;
    logic [8:0]      mem [DEPTH];

    logic [PW-1:0]   occupancy;
    logic [PW-1:0]   occ_next;
    logic            pop;

    assign payload_valid = (commit_ptr_reg != rd_ptr_reg);
    assign pop           = payload_valid && payload_ready;
    assign occupancy     = wr_ptr_reg - rd_ptr_reg;
    assign occ_next      = wr_ptr_next - rd_ptr_next;
    assign local_ready_next = (occ_next <= PW'(DEPTH - 2));

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        idx_next        = idx_reg;
        chk_next        = chk_reg;
        tmo_next        = tmo_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        rd_ptr_next     = rd_ptr_reg + PW'(pop);
        frame_ok_next   = 1'b0;
        frame_err_next  = 1'b0;
        err_code_next   = 2'd0;
        mem_we          = 1'b0;
        mem_waddr       = wr_ptr_reg[AW-1:0];
        mem_wdata       = {(idx_reg == len_reg - 8'd1), rx_data};

        if (state_reg == IDLE) begin
            tmo_next = '0;
            if (rx_valid && rx_data == SOF) begin
                state_next = LEN;
            end
        end else if (rx_valid) begin
            // A byte arriving on the timeout cycle still counts as in time.
            tmo_next = '0;
            case (state_reg)
                LEN: begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        frame_err_next = 1'b1;
                        err_code_next  = 2'd1;
                        state_next     = IDLE;
                    end else begin
                        len_next   = rx_data;
                        chk_next   = rx_data;
                        idx_next   = 8'd0;
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (occupancy == PW'(DEPTH)) begin
                        wr_ptr_next    = commit_ptr_reg;
                        frame_err_next = 1'b1;
                        err_code_next  = 2'd3;
                        state_next     = IDLE;
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + PW'(1);
                        chk_next    = chk_reg ^ rx_data;
                        idx_next    = idx_reg + 8'd1;
                        if (idx_reg == len_reg - 8'd1) begin
                            state_next = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (rx_data == chk_reg) begin
                        commit_ptr_next = wr_ptr_reg;
                        frame_ok_next   = 1'b1;
                    end else begin
                        wr_ptr_next    = commit_ptr_reg;
                        frame_err_next = 1'b1;
                        err_code_next  = 2'd2;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            wr_ptr_next    = commit_ptr_reg;
            frame_err_next = 1'b1;
            err_code_next  = 2'd3;
            tmo_next       = '0;
            state_next     = IDLE;
        end else begin
            tmo_next = tmo_reg + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            len_reg         <= 8'd0;
            idx_reg         <= 8'd0;
            chk_reg         <= 8'd0;
            tmo_reg         <= '0;
            wr_ptr_reg      <= '0;
            commit_ptr_reg  <= '0;
            rd_ptr_reg      <= '0;
            local_ready_reg <= 1'b1;
            frame_ok_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            err_code_reg    <= 2'd0;
        end else begin
            state_reg       <= state_next;
            len_reg         <= len_next;
            idx_reg         <= idx_next;
            chk_reg         <= chk_next;
            tmo_reg         <= tmo_next;
            wr_ptr_reg      <= wr_ptr_next;
            commit_ptr_reg  <= commit_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            local_ready_reg <= local_ready_next;
            frame_ok_reg    <= frame_ok_next;
            frame_err_reg   <= frame_err_next;
            err_code_reg    <= err_code_next;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Prefetch the head entry every cycle; committed entries were written at least
    // one cycle before the commit, so the read-before-write value is always current.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_reg <= 9'd0;
        end else begin
            rdata_reg <= mem[rd_ptr_next[AW-1:0]];
        end
    end

    assign payload_data = rdata_reg[7:0];
    assign payload_last = rdata_reg[8];
    assign local_ready  = local_ready_reg;
    assign frame_ok     = frame_ok_reg;
    assign frame_err    = frame_err_reg;
    assign err_code     = err_code_reg;

endmodule
